// File: rtl/mshr_pkg.sv
// Shared types and helpers for the MSHR controller.
//   entry_state_t : per-entry lifecycle IDLE -> ISSUE -> WAIT_RESP -> FILL -> IDLE
//   idx_w()       : entry index width for a given entry count
//   line_addr()   : clears the line-offset bits of a byte address
package mshr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    FILL
  } entry_state_t;

  function automatic int unsigned idx_w(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  // Works on a 64-bit container; callers cast to their own address width.
  function automatic logic [63:0] line_addr(input logic [63:0] addr, input int unsigned off_w);
    return addr & ~((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/mshr_if.sv
// Bundle of the MSHR controller's handshake channels.
//   miss_*     : cache miss path into the controller
//   mem_req_*  : line requests out to memory
//   mem_resp_* : refill completions from memory (always accepted)
//   fill_*     : refill hand-back to the cache
// Modports: slave = the controller, master = the surrounding cache/memory side.
interface mshr_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned MERGE_W = 2
) ();

  logic               miss_valid;
  logic [ADDR_W-1:0]  miss_addr;
  logic               miss_ready;
  logic [IDX_W-1:0]   miss_id;
  logic               miss_merged;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic [IDX_W-1:0]   mem_req_id;

  logic               mem_resp_valid;
  logic [IDX_W-1:0]   mem_resp_id;

  logic               fill_valid;
  logic               fill_ready;
  logic [IDX_W-1:0]   fill_id;
  logic [ADDR_W-1:0]  fill_addr;
  logic [MERGE_W-1:0] fill_merges;

  modport slave (
    input  miss_valid, miss_addr, mem_req_ready, mem_resp_valid, mem_resp_id, fill_ready,
    output miss_ready, miss_id, miss_merged, mem_req_valid, mem_req_addr, mem_req_id,
    output fill_valid, fill_id, fill_addr, fill_merges
  );

  modport master (
    output miss_valid, miss_addr, mem_req_ready, mem_resp_valid, mem_resp_id, fill_ready,
    input  miss_ready, miss_id, miss_merged, mem_req_valid, mem_req_addr, mem_req_id,
    input  fill_valid, fill_id, fill_addr, fill_merges
  );

endinterface

// File: rtl/mshr_rr_arbiter.sv
// N-way round-robin arbiter with advance enable.
//   req       : request vector
//   ack       : grant accepted this cycle; pointer moves past the winner only then
//   gnt_valid : some request is granted
//   gnt_idx   : granted index, held stable until ack
// N must be a power of two so the pointer wraps naturally.
module mshr_rr_arbiter
  import mshr_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             ack,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_any = 1'b0;
    pick_idx = ptr_q;
    cand     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!pick_any && req[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // A presented-but-stalled grant is locked so newly arriving requests cannot
  // change it; the locked requester cannot drop its request without an ack.
  assign gnt_valid = lock_q | pick_any;
  assign gnt_idx   = lock_q ? lock_idx_q : pick_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (gnt_valid && ack) begin
      ptr_q  <= gnt_idx + 1'b1;
      lock_q <= 1'b0;
    end else if (gnt_valid) begin
      lock_q     <= 1'b1;
      lock_idx_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/mshr_ctrl.sv
// Miss-status controller: tracks up to ENTRIES outstanding line misses, merges
// secondary misses into in-flight entries, issues one memory request per primary
// miss and sequences refills back to the cache.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : mshr_if.slave (miss, mem_req, mem_resp, fill channels)
//   full     : every entry is non-IDLE
//   resp_err : sticky; a response arrived for an entry not in WAIT_RESP
module mshr_ctrl
  import mshr_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned OFF_W   = 4,
  parameter int unsigned MERGE_W = 2
) (
  input  logic  clk,
  input  logic  rst,
  mshr_if.slave bus,
  output logic  full,
  output logic  resp_err
);

  localparam int unsigned      IDX_W   = idx_w(ENTRIES);
  localparam logic [MERGE_W-1:0] CNT_MAX = '1;

  entry_state_t       state_q [ENTRIES];
  logic [ADDR_W-1:0]  addr_q  [ENTRIES];
  logic [MERGE_W-1:0] cnt_q   [ENTRIES];
  logic               resp_err_q;

  logic [ADDR_W-1:0]  miss_line;
  logic [ENTRIES-1:0] idle_vec, issue_vec, match_vec;
  logic               match_any, free_any, can_merge, fill_any;
  logic [IDX_W-1:0]   match_idx, free_idx, fill_idx, gnt_idx;
  logic               gnt_valid, miss_hs, issue_hs, fill_hs;

  assign miss_line = ADDR_W'(line_addr(64'(bus.miss_addr), OFF_W));

  always_comb begin
    idle_vec  = '0;
    issue_vec = '0;
    match_vec = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      idle_vec[i]  = (state_q[i] == IDLE);
      issue_vec[i] = (state_q[i] == ISSUE);
      match_vec[i] = (state_q[i] != IDLE) && (addr_q[i] == miss_line);
    end
  end

  // At most one live entry can hold a given line, so match_idx is unambiguous.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    fill_any  = 1'b0;
    fill_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (idle_vec[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (state_q[i] == FILL) begin
        fill_any = 1'b1;
        fill_idx = IDX_W'(i);
      end
    end
    // Merges only while the refill is still outstanding; a FILL match stalls.
    can_merge = match_any && (state_q[match_idx] inside {ISSUE, WAIT_RESP})
                && (cnt_q[match_idx] != CNT_MAX);
  end

  assign bus.miss_ready  = match_any ? can_merge : free_any;
  assign bus.miss_merged = match_any;
  assign bus.miss_id     = match_any ? match_idx : free_idx;
  assign miss_hs         = bus.miss_valid && bus.miss_ready;

  mshr_rr_arbiter #(
    .N     (ENTRIES),
    .IDX_W (IDX_W)
  ) u_issue_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (issue_vec),
    .ack       (bus.mem_req_ready),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign bus.mem_req_valid = gnt_valid;
  assign bus.mem_req_id    = gnt_idx;
  assign bus.mem_req_addr  = addr_q[gnt_idx];
  assign issue_hs          = gnt_valid && bus.mem_req_ready;

  assign bus.fill_valid  = fill_any;
  assign bus.fill_id     = fill_idx;
  assign bus.fill_addr   = addr_q[fill_idx];
  assign bus.fill_merges = cnt_q[fill_idx];
  assign fill_hs         = fill_any && bus.fill_ready;

  assign full     = ~|idle_vec;
  assign resp_err = resp_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        state_q[i] <= IDLE;
        addr_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
      resp_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        unique case (state_q[i])
          IDLE: begin
            if (miss_hs && !match_any && (free_idx == IDX_W'(i))) begin
              state_q[i] <= ISSUE;
              addr_q[i]  <= miss_line;
              cnt_q[i]   <= '0;
            end
          end
          ISSUE: begin
            if (issue_hs && (gnt_idx == IDX_W'(i))) state_q[i] <= WAIT_RESP;
          end
          WAIT_RESP: begin
            if (bus.mem_resp_valid && (bus.mem_resp_id == IDX_W'(i))) state_q[i] <= FILL;
          end
          FILL: begin
            if (fill_hs && (fill_idx == IDX_W'(i))) begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end
          end
          default: state_q[i] <= IDLE;
        endcase
        // A merge landing in the same cycle as the response is still counted.
        if (miss_hs && match_any && (match_idx == IDX_W'(i))) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      if (bus.mem_resp_valid && (state_q[bus.mem_resp_id] != WAIT_RESP)) resp_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mshr_ctrl.sv
module tb_mshr_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic full;
  logic resp_err;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  mshr_if #(.ADDR_W(32), .IDX_W(2), .MERGE_W(2)) bus ();

  mshr_ctrl #(
    .ENTRIES (4),
    .ADDR_W  (32),
    .OFF_W   (4),
    .MERGE_W (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .full     (full),
    .resp_err (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One row per clock cycle: inputs held for the cycle, outputs checked mid-cycle.
  typedef struct {
    int unsigned mv, ma, rqr, rv, rid, frdy;
    int unsigned mrdy, mid, mgd;
    int unsigned rqv, rqa, rqid;
    int unsigned fv, fid, fa, fm;
    int unsigned full, err;
  } vec_t;

  localparam int NV = 19;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input int unsigned mv, ma, rqr, rv, rid, frdy);
    bus.miss_valid     = mv[0];
    bus.miss_addr      = ma;
    bus.mem_req_ready  = rqr[0];
    bus.mem_resp_valid = rv[0];
    bus.mem_resp_id    = rid[1:0];
    bus.fill_ready     = frdy[0];
  endtask

  // Asserts reset mid-cycle and checks that everything drops immediately.
  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk({tag, " mem_req_valid"}, bus.mem_req_valid, 1'b0);
    chk({tag, " fill_valid"}, bus.fill_valid, 1'b0);
    chk({tag, " full"}, full, 1'b0);
    chk({tag, " resp_err"}, resp_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    //          mv ma        rqr rv rid fr  mrdy mid mgd rqv rqa       rqid fv fid fa        fm full err
    vec[0]  = '{1, 'h1000,   0,  0, 0,  0,  1,   0,  0,  0,  0,        0,   0, 0,  0,        0, 0,   0};
    vec[1]  = '{1, 'h1004,   0,  0, 0,  0,  1,   0,  1,  1,  'h1000,   0,   0, 0,  0,        0, 0,   0};
    vec[2]  = '{1, 'h1008,   1,  0, 0,  0,  1,   0,  1,  1,  'h1000,   0,   0, 0,  0,        0, 0,   0};
    vec[3]  = '{0, 'h2000,   0,  0, 0,  0,  1,   0,  0,  0,  0,        0,   0, 0,  0,        0, 0,   0};
    vec[4]  = '{0, 'h2000,   0,  1, 0,  0,  1,   0,  0,  0,  0,        0,   0, 0,  0,        0, 0,   0};
    vec[5]  = '{1, 'h1004,   0,  0, 0,  0,  0,   0,  0,  0,  0,        0,   1, 0,  'h1000,   2, 0,   0};
    vec[6]  = '{0, 'h2000,   0,  0, 0,  1,  1,   0,  0,  0,  0,        0,   1, 0,  'h1000,   2, 0,   0};
    vec[7]  = '{1, 'h1000,   0,  0, 0,  0,  1,   0,  0,  0,  0,        0,   0, 0,  0,        0, 0,   0};
    vec[8]  = '{1, 'h1004,   0,  0, 0,  0,  1,   0,  1,  1,  'h1000,   0,   0, 0,  0,        0, 0,   0};
    vec[9]  = '{1, 'h1008,   0,  0, 0,  0,  1,   0,  1,  1,  'h1000,   0,   0, 0,  0,        0, 0,   0};
    vec[10] = '{1, 'h100C,   0,  0, 0,  0,  1,   0,  1,  1,  'h1000,   0,   0, 0,  0,        0, 0,   0};
    vec[11] = '{1, 'h1008,   0,  0, 0,  0,  0,   0,  0,  1,  'h1000,   0,   0, 0,  0,        0, 0,   0};
    vec[12] = '{1, 'h2014,   0,  0, 0,  0,  1,   1,  0,  1,  'h1000,   0,   0, 0,  0,        0, 0,   0};
    vec[13] = '{0, 'h5000,   1,  0, 0,  0,  1,   0,  0,  1,  'h1000,   0,   0, 0,  0,        0, 0,   0};
    vec[14] = '{0, 'h5000,   0,  1, 3,  0,  1,   0,  0,  1,  'h2010,   1,   0, 0,  0,        0, 0,   0};
    vec[15] = '{0, 'h5000,   1,  0, 0,  0,  1,   0,  0,  1,  'h2010,   1,   0, 0,  0,        0, 0,   1};
    vec[16] = '{0, 'h5000,   0,  1, 0,  0,  1,   0,  0,  0,  0,        0,   0, 0,  0,        0, 0,   1};
    vec[17] = '{0, 'h5000,   0,  0, 0,  1,  1,   0,  0,  0,  0,        0,   1, 0,  'h1000,   3, 0,   1};
    vec[18] = '{0, 'h5000,   0,  0, 0,  0,  1,   0,  0,  0,  0,        0,   0, 0,  0,        0, 0,   1};

    // Power-on reset state.
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("por mem_req_valid", bus.mem_req_valid, 1'b0);
    chk("por fill_valid", bus.fill_valid, 1'b0);
    chk("por full", full, 1'b0);
    chk("por resp_err", resp_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      set_in(vec[i].mv, vec[i].ma, vec[i].rqr, vec[i].rv, vec[i].rid, vec[i].frdy);
      #1;
      chk($sformatf("v%0d miss_ready", i), bus.miss_ready, vec[i].mrdy);
      if (vec[i].mv != 0 && vec[i].mrdy != 0) begin
        chk($sformatf("v%0d miss_id", i), bus.miss_id, vec[i].mid);
        chk($sformatf("v%0d miss_merged", i), bus.miss_merged, vec[i].mgd);
      end
      chk($sformatf("v%0d mem_req_valid", i), bus.mem_req_valid, vec[i].rqv);
      if (vec[i].rqv != 0) begin
        chk($sformatf("v%0d mem_req_addr", i), bus.mem_req_addr, vec[i].rqa);
        chk($sformatf("v%0d mem_req_id", i), bus.mem_req_id, vec[i].rqid);
      end
      chk($sformatf("v%0d fill_valid", i), bus.fill_valid, vec[i].fv);
      if (vec[i].fv != 0) begin
        chk($sformatf("v%0d fill_id", i), bus.fill_id, vec[i].fid);
        chk($sformatf("v%0d fill_addr", i), bus.fill_addr, vec[i].fa);
        chk($sformatf("v%0d fill_merges", i), bus.fill_merges, vec[i].fm);
      end
      chk($sformatf("v%0d full", i), full, vec[i].full);
      chk($sformatf("v%0d resp_err", i), resp_err, vec[i].err);
    end

    // Fill all four entries with memory stalled, then drain in round-robin order.
    reset_dut("rst1");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_in(1, 'h100 * (k + 1), 0, 0, 0, 0);
      #1;
      chk($sformatf("alloc%0d miss_ready", k), bus.miss_ready, 1'b1);
      chk($sformatf("alloc%0d miss_id", k), bus.miss_id, k);
      chk($sformatf("alloc%0d miss_merged", k), bus.miss_merged, 1'b0);
    end
    @(negedge clk);
    set_in(1, 'h500, 0, 0, 0, 0);
    #1;
    chk("full flag", full, 1'b1);
    chk("full miss_ready", bus.miss_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_in(0, 0, 1, 0, 0, 0);
      #1;
      chk($sformatf("rr%0d mem_req_valid", k), bus.mem_req_valid, 1'b1);
      chk($sformatf("rr%0d mem_req_id", k), bus.mem_req_id, k);
      chk($sformatf("rr%0d mem_req_addr", k), bus.mem_req_addr, 'h100 * (k + 1));
    end
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("rr done mem_req_valid", bus.mem_req_valid, 1'b0);

    // Out-of-order responses 2 then 0 with the cache stalled.
    @(negedge clk);
    set_in(0, 0, 0, 1, 2, 0);
    #1;
    chk("ooo fill_valid before", bus.fill_valid, 1'b0);
    @(negedge clk);
    set_in(0, 0, 0, 1, 0, 0);
    #1;
    chk("ooo fill_valid after resp2", bus.fill_valid, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("ooo hold%0d fill_valid", k), bus.fill_valid, 1'b1);
      chk($sformatf("ooo hold%0d fill_id", k), bus.fill_id, 2'd0);
      chk($sformatf("ooo hold%0d fill_addr", k), bus.fill_addr, 32'h100);
    end
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 1);
    #1;
    chk("ooo hs0 fill_id", bus.fill_id, 2'd0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 1);
    #1;
    chk("ooo second fill_id", bus.fill_id, 2'd2);
    chk("ooo second fill_addr", bus.fill_addr, 32'h300);
    chk("ooo second fill_merges", bus.fill_merges, 2'd0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("ooo drained fill_valid", bus.fill_valid, 1'b0);
    chk("ooo drained full", full, 1'b0);

    // Merge and response to entry 1 in the same cycle.
    @(negedge clk);
    set_in(1, 'h208, 0, 1, 1, 0);
    #1;
    chk("simul miss_ready", bus.miss_ready, 1'b1);
    chk("simul miss_merged", bus.miss_merged, 1'b1);
    chk("simul miss_id", bus.miss_id, 2'd1);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("simul fill_valid", bus.fill_valid, 1'b1);
    chk("simul fill_id", bus.fill_id, 2'd1);
    chk("simul fill_merges", bus.fill_merges, 2'd1);

    // Response to an entry that has just gone IDLE.
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 1);
    #1;
    chk("idle-resp hs fill_id", bus.fill_id, 2'd1);
    @(negedge clk);
    set_in(0, 0, 0, 1, 1, 0);
    #1;
    chk("idle-resp err before", resp_err, 1'b0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("idle-resp err after", resp_err, 1'b1);
    chk("idle-resp fill_valid", bus.fill_valid, 1'b0);

    // Reset with entry 0 requesting and entry 3 waiting; a late response errors.
    @(negedge clk);
    set_in(1, 'h700, 0, 0, 0, 0);
    #1;
    chk("pre-rst miss_id", bus.miss_id, 2'd0);
    reset_dut("rst2");
    @(negedge clk);
    set_in(0, 0, 0, 1, 3, 0);
    #1;
    chk("late-resp err before", resp_err, 1'b0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("late-resp err after", resp_err, 1'b1);
    chk("late-resp fill_valid", bus.fill_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
